// File: rtl/gclk_mon_pkg.sv
// gclk_mon_pkg: shared definitions for the global-clock stability monitor.
//   - DEF_* : default parameter values for gclk_stable_monitor
//   - chan_status_t : per-channel registered status {stable, settled, viol}
//   - cnt_max() : saturation value of a CNT_W-bit stable-run counter
package gclk_mon_pkg;

    localparam int DEF_CHANNELS   = 4;
    localparam int DEF_WIDTH      = 8;
    localparam int DEF_CNT_W      = 4;
    localparam int DEF_MIN_STABLE = 3;

    typedef struct packed {
        logic stable;
        logic settled;
        logic viol;
    } chan_status_t;

    function automatic int unsigned cnt_max(input int unsigned cnt_w);
        return (32'd1 << cnt_w) - 32'd1;
    endfunction

endpackage

// File: rtl/gclk_stable_chan.sv
// gclk_stable_chan: one monitored channel.
// Ports:
//   clk, rst     - global clock, async active-high reset
//   en_i         - monitor enable (shared)
//   valid_i      - past sample is valid (shared warm-up flag from the top)
//   lock_i       - channel must not change
//   clr_i        - synchronous clear of the sticky violation bit
//   sig_i        - this channel's sample
//   stable_o     - sample equalled the previous one (registered)
//   settled_o    - run counter >= MIN_STABLE (registered)
//   run_cnt_o    - saturating stable-run counter
//   viol_o       - sticky locked-channel violation
//   viol_next_o  - next-state of viol_o, for the registered OR in the top
module gclk_stable_chan
    import gclk_mon_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int MIN_STABLE = DEF_MIN_STABLE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             valid_i,
    input  logic             lock_i,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] sig_i,
    output logic             stable_o,
    output logic             settled_o,
    output logic [CNT_W-1:0] run_cnt_o,
    output logic             viol_o,
    output logic             viol_next_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));
    localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_STABLE);

    logic [WIDTH-1:0] past_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_next;
    chan_status_t     status_q;
    logic             eq;
    logic             viol_next;

    always_comb begin
        eq       = (sig_i == past_q);
        cnt_next = cnt_q;
        if (en_i) begin
            // warm-up edge and any change both restart the run from 0
            if (!valid_i || !eq)
                cnt_next = '0;
            else if (cnt_q != CNT_MAX)
                cnt_next = cnt_q + 1'b1;
        end
        // set has priority over clear; clear is honoured even while disabled
        viol_next = (status_q.viol & ~clr_i) | (en_i & valid_i & ~eq & lock_i);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            past_q   <= '0;
            cnt_q    <= '0;
            status_q <= '0;
        end else begin
            status_q.viol <= viol_next;
            cnt_q         <= cnt_next;
            if (en_i) begin
                past_q           <= sig_i;
                status_q.stable  <= valid_i & eq;
                status_q.settled <= valid_i & (cnt_next >= MIN_CNT);
            end else begin
                status_q.stable  <= 1'b0;
                status_q.settled <= 1'b0;
            end
        end
    end

    assign stable_o    = status_q.stable;
    assign settled_o   = status_q.settled;
    assign viol_o      = status_q.viol;
    assign run_cnt_o   = cnt_q;
    assign viol_next_o = viol_next;

endmodule

// File: rtl/gclk_stable_monitor.sv
// gclk_stable_monitor: multi-channel global-clock stability monitor.
// Compares every channel's sample with the previous global-clock sample,
// keeps a saturating stable-run count and a sticky violation flag for
// locked channels.
// Ports:
//   clk        - global clock (posedge)
//   rst        - asynchronous active-high reset
//   en_i       - enable; low freezes counters and forces warm-up
//   sig_i      - CHANNELS*WIDTH samples, channel c at [c*WIDTH +: WIDTH]
//   lock_i     - per-channel must-not-change
//   clr_i      - synchronous clear of all violation bits
//   stable_o   - per-channel registered stability
//   settled_o  - per-channel run count >= MIN_STABLE
//   run_cnt_o  - per-channel run counts, CNT_W bits each
//   viol_o     - per-channel sticky violation
//   any_viol_o - registered OR of viol_o
// Optional: define GCLK_STABLE_MONITOR_ASSERT_EN to add a global clocking
// block and per-channel concurrent property checks.
module gclk_stable_monitor
  import gclk_mon_pkg::*;
#(
  parameter int CHANNELS   = DEF_CHANNELS,
  parameter int WIDTH      = DEF_WIDTH,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int MIN_STABLE = DEF_MIN_STABLE
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en_i,
  input  logic [CHANNELS*WIDTH-1:0] sig_i,
  input  logic [CHANNELS-1:0]       lock_i,
  input  logic                      clr_i,
  output logic [CHANNELS-1:0]       stable_o,
  output logic [CHANNELS-1:0]       settled_o,
  output logic [CHANNELS*CNT_W-1:0] run_cnt_o,
  output logic [CHANNELS-1:0]       viol_o,
  output logic                      any_viol_o
);

  logic                valid_q;
  logic                any_viol_q;
  logic [CHANNELS-1:0] viol_next;

  // valid drops whenever disabled, so re-enabling repeats warm-up
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= 1'b0;
      any_viol_q <= 1'b0;
    end else begin
      valid_q    <= en_i;
      any_viol_q <= |viol_next;
    end
  end

  assign any_viol_o = any_viol_q;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    gclk_stable_chan #(
      .WIDTH      (WIDTH),
      .CNT_W      (CNT_W),
      .MIN_STABLE (MIN_STABLE)
    ) u_chan (
      .clk         (clk),
      .rst         (rst),
      .en_i        (en_i),
      .valid_i     (valid_q),
      .lock_i      (lock_i[c]),
      .clr_i       (clr_i),
      .sig_i       (sig_i[c*WIDTH +: WIDTH]),
      .stable_o    (stable_o[c]),
      .settled_o   (settled_o[c]),
      .run_cnt_o   (run_cnt_o[c*CNT_W +: CNT_W]),
      .viol_o      (viol_o[c]),
      .viol_next_o (viol_next[c])
    );
  end

`ifdef GCLK_STABLE_MONITOR_ASSERT_EN
  global clocking gclk @(posedge clk); endclocking

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chk
    a_stable_hi: assert property (@(posedge clk) disable iff (rst)
      (en_i && valid_q && $stable(sig_i[c*WIDTH +: WIDTH])) |=> stable_o[c]);
    a_stable_lo: assert property (@(posedge clk) disable iff (rst)
      (en_i && valid_q && !$stable(sig_i[c*WIDTH +: WIDTH])) |=> !stable_o[c]);
    a_viol_sticky: assert property (@(posedge clk) disable iff (rst)
      (viol_o[c] && !clr_i) |=> viol_o[c]);
    a_cnt_mono: assert property (@(posedge clk) disable iff (rst)
      1'b1 |=> (run_cnt_o[c*CNT_W +: CNT_W] == '0) ||
               (run_cnt_o[c*CNT_W +: CNT_W] >= $past(run_cnt_o[c*CNT_W +: CNT_W])));
  end
`endif

endmodule

// File: tb/tb_gclk_stable_monitor.sv
// Testbench for gclk_stable_monitor: directed scenarios plus randomized
// traffic, checked by a scoreboard fed from a behavioural reference model.
module tb_gclk_stable_monitor;

    localparam int CH   = 4;
    localparam int W    = 8;
    localparam int CW   = 4;
    localparam int MINS = 3;
    localparam int CMAX = 15;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              en_i = 1'b0;
    logic              clr_i = 1'b0;
    logic [CH*W-1:0]   sig_i = '0;
    logic [CH-1:0]     lock_i = '0;
    logic [CH-1:0]     stable_o, settled_o, viol_o;
    logic [CH*CW-1:0]  run_cnt_o;
    logic              any_viol_o;

    always #5 clk = ~clk;

    gclk_stable_monitor #(
        .CHANNELS   (CH),
        .WIDTH      (W),
        .CNT_W      (CW),
        .MIN_STABLE (MINS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en_i       (en_i),
        .sig_i      (sig_i),
        .lock_i     (lock_i),
        .clr_i      (clr_i),
        .stable_o   (stable_o),
        .settled_o  (settled_o),
        .run_cnt_o  (run_cnt_o),
        .viol_o     (viol_o),
        .any_viol_o (any_viol_o)
    );

    typedef struct {
        logic [CH-1:0]    stable;
        logic [CH-1:0]    settled;
        logic [CH-1:0]    viol;
        logic             any;
        logic [CH*CW-1:0] cnt;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int passed = 0;

    // stimulus for the next edge
    int      sv[CH];
    bit      r = 1'b1;
    bit      en = 1'b1;
    bit      clr = 1'b0;
    bit [CH-1:0] lk = '0;

    // reference model state
    int  m_past[CH];
    bit  m_warm = 1'b0;
    int  m_run[CH];
    bit  m_viol[CH];
    bit  m_stable[CH];
    bit  m_settled[CH];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic int cnt_of(int c);
        return int'(run_cnt_o[c*CW +: CW]);
    endfunction

    // One clock edge of the behavioural model; pushes the expected outputs.
    task automatic model_edge();
        exp_t e;
        bit   anyv;
        if (r) begin
            m_warm = 1'b0;
            for (int c = 0; c < CH; c++) begin
                m_past[c] = 0; m_run[c] = 0; m_viol[c] = 1'b0;
                m_stable[c] = 1'b0; m_settled[c] = 1'b0;
            end
        end else begin
            for (int c = 0; c < CH; c++) begin
                if (clr) m_viol[c] = 1'b0;
                if (!en) begin
                    m_stable[c] = 1'b0;
                    m_settled[c] = 1'b0;
                end else if (!m_warm) begin
                    m_past[c] = sv[c];
                    m_run[c] = 0;
                    m_stable[c] = 1'b0;
                    m_settled[c] = 1'b0;
                end else begin
                    bit same;
                    same = (sv[c] == m_past[c]);
                    m_stable[c] = same;
                    m_run[c] = same ? ((m_run[c] < CMAX) ? m_run[c] + 1 : CMAX) : 0;
                    m_settled[c] = (m_run[c] >= MINS);
                    if (!same && lk[c]) m_viol[c] = 1'b1;
                    m_past[c] = sv[c];
                end
            end
            m_warm = en;
        end
        anyv = 1'b0;
        for (int c = 0; c < CH; c++) begin
            e.stable[c]  = m_stable[c];
            e.settled[c] = m_settled[c];
            e.viol[c]    = m_viol[c];
            e.cnt[c*CW +: CW] = CW'(m_run[c]);
            anyv |= m_viol[c];
        end
        e.any = anyv;
        q.push_back(e);
    endtask

    task automatic step();
        @(negedge clk);
        rst    = r;
        en_i   = en;
        clr_i  = clr;
        lock_i = lk;
        for (int c = 0; c < CH; c++) sig_i[c*W +: W] = W'(sv[c]);
        model_edge();
    endtask

    task automatic post();
        @(posedge clk);
        #2;
    endtask

    // scoreboard monitor: one expected entry per edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("sb stable_o",   32'(stable_o),   32'(e.stable));
                chk("sb settled_o",  32'(settled_o),  32'(e.settled));
                chk("sb run_cnt_o",  32'(run_cnt_o),  32'(e.cnt));
                chk("sb viol_o",     32'(viol_o),     32'(e.viol));
                chk("sb any_viol_o", 32'(any_viol_o), 32'(e.any));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        sv[0] = 'hA5; sv[1] = 'h3C; sv[2] = 'h00; sv[3] = 'h55;
        r = 1'b1;
        step(); step();

        // warm-up after reset
        r = 1'b0;
        step(); post();
        chk("warmup stable0", 32'(stable_o[0]), 0);
        chk("warmup cnt0", cnt_of(0), 0);
        step(); post();
        chk("edge2 stable0", 32'(stable_o[0]), 1);
        chk("edge2 cnt0", cnt_of(0), 1);
        chk("edge2 settled0", 32'(settled_o[0]), 0);
        step(); post();
        chk("edge3 cnt0", cnt_of(0), 2);
        step(); post();
        chk("edge4 cnt0", cnt_of(0), 3);
        chk("edge4 settled0", 32'(settled_o[0]), 1);

        // saturation
        repeat (17) step();
        post();
        chk("sat cnt1", cnt_of(1), 15);
        chk("sat settled1", 32'(settled_o[1]), 1);

        // change resets the run
        sv[2] = 'h01;
        step(); post();
        chk("chg stable2", 32'(stable_o[2]), 0);
        chk("chg cnt2", cnt_of(2), 0);
        chk("chg settled2", 32'(settled_o[2]), 0);
        chk("chg viol2", 32'(viol_o[2]), 0);

        // locked violation and clear priority
        lk[3] = 1'b1; sv[3] = 'h56;
        step(); post();
        chk("lock viol3", 32'(viol_o[3]), 1);
        chk("lock any", 32'(any_viol_o), 1);
        clr = 1'b1; sv[3] = 'h57;
        step(); post();
        chk("clr+viol viol3", 32'(viol_o[3]), 1);
        step(); post();
        chk("clr viol3", 32'(viol_o[3]), 0);
        chk("clr any", 32'(any_viol_o), 0);
        clr = 1'b0;

        // enable gap
        repeat (3) step();
        post();
        chk("pre-gap cnt2", cnt_of(2), 6);
        en = 1'b0;
        repeat (3) step();
        post();
        chk("gap stable", 32'(stable_o), 0);
        chk("gap settled", 32'(settled_o), 0);
        chk("gap cnt2", cnt_of(2), 6);
        en = 1'b1;
        step(); post();
        chk("reen warmup stable2", 32'(stable_o[2]), 0);
        chk("reen warmup cnt2", cnt_of(2), 0);
        step(); post();
        chk("reen stable2", 32'(stable_o[2]), 1);
        chk("reen cnt2", cnt_of(2), 1);

        // async reset between edges
        sv[3] = 'h58;
        step(); post();
        chk("pre-rst viol", 32'(viol_o), 32'h8);
        #1;
        r = 1'b1; rst = 1'b1;
        #1;
        chk("async stable", 32'(stable_o), 0);
        chk("async settled", 32'(settled_o), 0);
        chk("async cnt", 32'(run_cnt_o), 0);
        chk("async viol", 32'(viol_o), 0);
        chk("async any", 32'(any_viol_o), 0);
        step();
        r = 1'b0; lk = '0;

        // randomized traffic
        repeat (300) begin
            en  = ($urandom_range(9) != 0);
            clr = ($urandom_range(11) == 0);
            lk  = CH'($urandom);
            for (int c = 0; c < CH; c++)
                if ($urandom_range(4) == 0) sv[c] = int'($urandom_range(3));
            step();
        end

        @(posedge clk);
        #3;
        chk("scoreboard drained", q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/gclk_stable_monitor.md
Name: gclk_stable_monitor

Overview:
- Parametrised, multi-channel, synthesizable successor to the single-bit, single-property global-clock stability check.
- Every clk edge, it compares each channel's sample with the previous global-clock sample and reports per-channel stability.
- Per channel it also keeps a saturating stable-run length and a sticky violation flag for channels the system declares locked.
- Sits beside the global clocking block in the assertion/checker layer; feeds status registers and test benches.

Parameters:
- CHANNELS, 4, number of independently monitored channels.
- WIDTH, 8, bits per channel.
- CNT_W, 4, width of the per-channel stable-run counter.
- MIN_STABLE, 3, run length at or above which settled_o asserts; legal range 1..2^CNT_W-1.

Ports:
- clk  input  1  global clock; all sampling on posedge.
- rst  input  1  asynchronous, active-high reset.
- en_i  input  1  monitor enable; low freezes counters and forces warm-up on re-enable.
- sig_i  input  CHANNELS*WIDTH  monitored signals; channel c occupies bits [c*WIDTH +: WIDTH].
- lock_i  input  CHANNELS  channel declared must-not-change.
- clr_i  input  1  synchronous clear of all sticky violation bits.
- stable_o  output  CHANNELS  registered per-channel equivalent of $stable_gclk.
- settled_o  output  CHANNELS  run counter >= MIN_STABLE.
- run_cnt_o  output  CHANNELS*CNT_W  per-channel saturating stable-run count.
- viol_o  output  CHANNELS  sticky: a locked channel changed.
- any_viol_o  output  1  OR of viol_o, registered.

Behaviour:
- Reset (async, rst=1): past samples, valid, stable_o, settled_o, run_cnt_o, viol_o and any_viol_o all go to 0 immediately. Release is sampled at the next posedge.
- Warm-up: valid_q is 0 after reset.
  - The first posedge with en_i=1 captures sig_i into past_q and sets valid_q.
  - No comparison is made on that edge (cycle-0 corner case); stable_o stays 0.
- Compare: on each posedge with en_i=1 and valid_q=1, eq[c] = (sig_i chan c == past_q[c]).
  - stable_o[c] <= eq[c].
  - past_q[c] <= sig_i chan c.
  - Latency from sample edge to stable_o is 1 cycle.
- Run counter:
  - eq → increment, saturating at 2^CNT_W-1 (no wrap).
  - !eq → load 0.
  - settled_o[c] <= (next count >= MIN_STABLE), so it updates on the same edge as run_cnt_o.
- Violation: eq[c]=0 with lock_i[c]=1 on a comparing edge → viol_o[c] <= 1.
  - clr_i=1 clears all viol bits on that edge.
  - A violation on the same edge as clr_i wins: the bit is set.
- any_viol_o <= |next viol; 1 cycle, aligned with viol_o.
- en_i=0:
  - valid_q <= 0; stable_o and settled_o <= 0.
  - run_cnt_o and viol_o hold.
  - Re-enabling repeats warm-up, then counting resumes from 0 on the first compare. The counter is reloaded to 0 at warm-up.
- Channels are fully independent; lock_i changes take effect on the same edge they are sampled.

Optional Feature:
- Macro: GCLK_STABLE_MONITOR_ASSERT_EN.
- Defined: the module declares a global clocking block on posedge clk and embeds, per channel, concurrent properties checking that:
  - stable_o matches ##1 $stable_gclk of the channel slice, gated by valid;
  - viol_o is never cleared except by clr_i or rst;
  - run_cnt_o never decreases except to 0.
- All properties are disabled during rst.
- Undefined: no global clocking block and no assertions; synthesizable logic is identical.

Decomposition:
- Package gclk_mon_pkg holds:
  - function for the saturating counter max (2^CNT_W-1);
  - chan_status_t struct {stable, settled, viol};
  - localparam defaults.
- Sub-module gclk_stable_chan: one channel's past register, compare, counter, settled and sticky violation.
- The top generates CHANNELS instances, plus the enable/valid logic and the any_viol reduction.

Test Plan:
- Reset warm-up: rst 1→0, en_i=1, ch0 held 8'hA5 → stable_o[0]=0 at the first edge, 1 from the second edge on; run_cnt_o ch0=1,2,3; settled_o[0] rises with cnt=3.
- Saturation: ch1 held constant for 20 cycles → run_cnt_o ch1 stops at 15, no wrap; settled_o[1] stays 1.
- Change resets count: ch2 stable 5 cycles, then 8'h00→8'h01 → next edge stable_o[2]=0, run_cnt_o ch2=0, settled_o[2]=0; viol_o[2] stays 0 (lock low).
- Locked violation and clear priority: lock_i[3]=1, ch3 changes → viol_o[3]=1, any_viol_o=1 same edge. Then clr_i=1 with a concurrent ch3 change → viol_o[3] remains 1. clr_i with ch3 stable → 0.
- Enable gap: en_i=0 for 3 cycles mid-run with cnt=6 → stable_o=0, cnt holds 6. Re-enable → one warm-up edge with stable_o=0, then cnt restarts at 1.
- Async reset mid-run: assert rst between edges with viol_o=4'b1000 → all outputs 0 before the next posedge.
